// File: rtl/slave_tx_packer_if.sv
// ---------------------------------------------------------------------------
// slave_tx_packer_if
// Bundles the slave response bus (have_msg / len / show-ahead head byte and
// the per-slave read strobes) together with the byte-stream TX handshake.
//
// Signals:
//   have_msg_bus   [N_SLAVES]    per-slave "message pending"
//   len_bus        [8*N_SLAVES]  per-slave byte count, slice i = [8i+7:8i]
//   slave_data_bus [8*N_SLAVES]  per-slave FIFO head byte, slice i = [8i+7:8i]
//   rdreq_bus      [N_SLAVES]    per-slave FIFO read strobe
//   tx_data        [8]           outgoing byte
//   tx_valid                     tx_data valid
//   tx_ready                     sink accepts the byte this cycle
//   busy                         packer is framing a message
//   err_underrun                 one-cycle pulse on payload underrun
//
// Modports: slave  = the packer itself
//           master = the environment (slaves + TX sink)
// ---------------------------------------------------------------------------
interface slave_tx_packer_if #(
    parameter int N_SLAVES = 5
);
    logic [N_SLAVES-1:0]   have_msg_bus;
    logic [8*N_SLAVES-1:0] len_bus;
    logic [8*N_SLAVES-1:0] slave_data_bus;
    logic [N_SLAVES-1:0]   rdreq_bus;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;
    logic                  err_underrun;

    modport slave (
        input  have_msg_bus, len_bus, slave_data_bus, tx_ready,
        output rdreq_bus, tx_data, tx_valid, busy, err_underrun
    );

    modport master (
        output have_msg_bus, len_bus, slave_data_bus, tx_ready,
        input  rdreq_bus, tx_data, tx_valid, busy, err_underrun
    );
endinterface

// File: rtl/slave_tx_packer.sv
// ---------------------------------------------------------------------------
// slave_tx_packer
// Round-robin arbiter and framer for slave responses. A slave is eligible
// when it has a message pending with a non-zero length. The granted slave's
// show-ahead FIFO is drained one byte per accepted transfer and the message
// is emitted as SOF, ADDR, LEN, DATA... [, CHK] on a valid/ready byte stream.
//
// Ports:
//   sys_clk  system clock, all logic on the rising edge
//   rst      synchronous reset, active-high
//   bus      slave_tx_packer_if.slave (slave response bus + TX handshake)
//
// Parameters:
//   N_SLAVES  number of slave channels (1..8)
//   SOF_BYTE  start-of-frame marker
//
// Build option:
//   SLAVE_TX_CHECKSUM_EN  when defined, an XOR checksum of ADDR, LEN and all
//                         DATA bytes is appended as a final CHK byte.
// ---------------------------------------------------------------------------
module slave_tx_packer #(
    parameter int         N_SLAVES = 5,
    parameter logic [7:0] SOF_BYTE = 8'hA5
) (
    input  logic             sys_clk,
    input  logic             rst,
    slave_tx_packer_if.slave bus
);

`ifdef SLAVE_TX_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_SOF, S_ADDR, S_LEN, S_DATA, S_CHK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SOF, S_ADDR, S_LEN, S_DATA} state_t;
`endif

    state_t      state_reg, state_next;
    logic [2:0]  gnt_reg, gnt_next;
    logic [2:0]  rr_reg, rr_next;
    logic [7:0]  len_reg, len_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        under_reg, under_next;
`ifdef SLAVE_TX_CHECKSUM_EN
    logic [7:0]  chk_reg, chk_next;
`endif

    // Per-slave views of the flattened buses.
    logic [N_SLAVES-1:0] eligible;
    logic [7:0]          len_arr  [N_SLAVES];
    logic [7:0]          head_arr [N_SLAVES];

    genvar gi;
    generate
        for (gi = 0; gi < N_SLAVES; gi++) begin : g_slice
            assign len_arr[gi]  = bus.len_bus[8*gi +: 8];
            assign head_arr[gi] = bus.slave_data_bus[8*gi +: 8];
            assign eligible[gi] = bus.have_msg_bus[gi] && (bus.len_bus[8*gi +: 8] != 8'd0);
        end
    endgenerate

    // First eligible slave at or after the rr pointer, wrapping.
    logic       found;
    logic [2:0] pick;
    logic [2:0] rr_after_pick;

    always_comb begin
        logic [3:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            idx = {1'b0, rr_reg} + 4'(k);
            if (idx >= 4'(N_SLAVES)) begin
                idx = idx - 4'(N_SLAVES);
            end
            if (!found && eligible[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
    end

    assign rr_after_pick = (pick == 3'(N_SLAVES - 1)) ? 3'd0 : pick + 3'd1;

    logic [N_SLAVES-1:0] rdreq_c;
    logic [7:0]          tx_data_c;
    logic                tx_valid_c;
    logic                err_c;
    logic                xfer;
    logic                under_now;

    // Once the granted slave drops have_msg the rest of the frame is padded
    // with zeros; the sticky flag keeps padding even if have_msg returns.
    assign under_now = under_reg || !bus.have_msg_bus[gnt_reg];

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        rr_next    = rr_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        under_next = under_reg;
`ifdef SLAVE_TX_CHECKSUM_EN
        chk_next   = chk_reg;
`endif
        rdreq_c    = '0;
        err_c      = 1'b0;
        tx_data_c  = 8'h00;
        tx_valid_c = (state_reg != S_IDLE);
        xfer       = tx_valid_c && bus.tx_ready;

        case (state_reg)
            S_IDLE: begin
                if (found) begin
                    gnt_next   = pick;
                    len_next   = len_arr[pick];
                    cnt_next   = len_arr[pick];
                    rr_next    = rr_after_pick;
                    under_next = 1'b0;
                    state_next = S_SOF;
                end
            end
            S_SOF: begin
                tx_data_c = SOF_BYTE;
                if (xfer) state_next = S_ADDR;
            end
            S_ADDR: begin
                tx_data_c = {5'b0, gnt_reg};
                if (xfer) state_next = S_LEN;
            end
            S_LEN: begin
                tx_data_c = len_reg;
                if (xfer) state_next = S_DATA;
            end
            S_DATA: begin
                tx_data_c = under_now ? 8'h00 : head_arr[gnt_reg];
                if (!under_reg && !bus.have_msg_bus[gnt_reg]) begin
                    err_c      = 1'b1;
                    under_next = 1'b1;
                end
                if (xfer) begin
                    if (!under_now) rdreq_c[gnt_reg] = 1'b1;
                    cnt_next = cnt_reg - 8'd1;
                    if (cnt_reg == 8'd1) begin
`ifdef SLAVE_TX_CHECKSUM_EN
                        state_next = S_CHK;
`else
                        state_next = S_IDLE;
`endif
                    end
                end
            end
`ifdef SLAVE_TX_CHECKSUM_EN
            S_CHK: begin
                tx_data_c = chk_reg;
                if (xfer) state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase

`ifdef SLAVE_TX_CHECKSUM_EN
        // Checksum restarts on every grant and covers ADDR, LEN and DATA.
        if (state_reg == S_IDLE) begin
            chk_next = 8'h00;
        end else if (xfer && (state_reg == S_ADDR || state_reg == S_LEN || state_reg == S_DATA)) begin
            chk_next = chk_reg ^ tx_data_c;
        end
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            gnt_reg   <= '0;
            rr_reg    <= '0;
            len_reg   <= '0;
            cnt_reg   <= '0;
            under_reg <= 1'b0;
`ifdef SLAVE_TX_CHECKSUM_EN
            chk_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            rr_reg    <= rr_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            under_reg <= under_next;
`ifdef SLAVE_TX_CHECKSUM_EN
            chk_reg   <= chk_next;
`endif
        end
    end

    assign bus.rdreq_bus    = rdreq_c;
    assign bus.tx_data      = tx_data_c;
    assign bus.tx_valid     = tx_valid_c;
    assign bus.err_underrun = err_c;
    assign bus.busy         = (state_reg != S_IDLE);

endmodule
